// File: rtl/midi_msg_assembler_pkg.sv
// Shared constants and helpers for the MIDI message assembler.
// States, status-byte ranges, bit timing and normalisation.
package midi_pkg;

   localparam logic [7:0] NOTE_OFF      = 8'h80;
   localparam logic [7:0] NOTE_ON       = 8'h90;
   localparam logic [7:0] PROG_CHANGE   = 8'hC0;
   localparam logic [7:0] PITCH_BEND    = 8'hE0;
   localparam logic [7:0] SYS_COMMON_LO = 8'hF0;
   localparam logic [7:0] REALTIME_LO   = 8'hF8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_D1 = 2'd1;
   localparam logic [1:0] ST_WAIT_D2 = 2'd2;

   function automatic int clks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

   // 0 for anything that is not a channel-voice status.
   function automatic logic [1:0] data_count(
      input logic [7:0] s
   );
      if (s >= NOTE_OFF && s < PROG_CHANGE)
         return 2'd2;
      else if (s >= PROG_CHANGE && s < PITCH_BEND)
         return 2'd1;
      else if (s >= PITCH_BEND && s < SYS_COMMON_LO)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // Note-On with zero velocity means Note-Off.
   function automatic logic [23:0] normalise(
      input logic [7:0] s,
      input logic [7:0] d1,
      input logic [7:0] d2
   );
      if (s[7:4] == NOTE_ON[7:4] && d2 == 8'h00)
         return {NOTE_OFF[7:4], s[3:0], d1, 8'h00};
      return {s, d1, d2};
   endfunction

endpackage

// File: rtl/midi_msg_assembler_uart_rx.sv
// 8N1 byte receiver: 2-flop sync, half-bit start check, centre sampling.
// Ports: clk, rst_n, i_rx -> o_byte, o_strobe, o_frame_err (1-cycle pulses).
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 31250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_strobe,
   output logic       o_frame_err
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB + 1);
   localparam logic [CW-1:0] LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [1:0]    r_sync;
   logic          r_prev;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_strobe;
   logic          r_ferr;

   logic w_rx;
   logic w_fall;

   assign w_rx   = r_sync[1];
   assign w_fall = r_prev & ~w_rx;

   // Sync and edge flops reset low: a line that is low when reset
   // releases must go high and fall again before a frame starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= 2'b00;
         r_prev   <= 1'b0;
         r_state  <= RX_IDLE;
         r_cnt    <= '0;
         r_bit    <= 3'd0;
         r_shift  <= 8'h00;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_sync   <= {r_sync[0], i_rx};
         r_prev   <= w_rx;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
         unique case (r_state)
            RX_IDLE: begin
               if (w_fall) begin
                  r_state <= RX_START;
                  r_cnt   <= '0;
               end
            end
            RX_START: begin
               if (r_cnt == HALF) begin
                  r_cnt   <= '0;
                  r_bit   <= 3'd0;
                  r_state <= w_rx ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7)
                     r_state <= RX_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == LAST) begin
                  r_cnt    <= '0;
                  r_state  <= RX_IDLE;
                  r_strobe <= w_rx;
                  r_ferr   <= ~w_rx;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign o_byte      = r_shift;
   assign o_strobe    = r_strobe;
   assign o_frame_err = r_ferr;

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI serial in -> {status, data1, data2} channel-voice messages.
// Ports: clk, rst_n, rx -> midi[23:0], midi_valid, frame_err.
// Option: define MIDI_RUNNING_STATUS_EN to accept running status.
module midi_msg_assembler
   import midi_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 31250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [23:0] midi,
   output logic        midi_valid,
   output logic        frame_err
);

   logic [7:0] w_byte;
   logic       w_strobe;
   logic       w_ferr;

   midi_uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx        (rx),
      .o_byte      (w_byte),
      .o_strobe    (w_strobe),
      .o_frame_err (w_ferr)
   );

   logic [1:0]  r_state;
   logic [7:0]  r_status;
   logic [7:0]  r_d1;
   logic [23:0] r_midi;
   logic        r_valid;

   logic w_is_rt;
   logic w_is_sys;
   logic w_is_chan;
   logic w_rs_start;
   logic w_take_d1;
   logic w_one;

   assign w_is_rt   = (w_byte >= REALTIME_LO);
   assign w_is_sys  = (w_byte >= SYS_COMMON_LO) & ~w_is_rt;
   assign w_is_chan = w_byte[7] & (w_byte < SYS_COMMON_LO);

   // A cleared stored status reads 0, so bit 7 marks a valid one.
`ifdef MIDI_RUNNING_STATUS_EN
   assign w_rs_start = (r_state == ST_IDLE) & r_status[7];
`else
   assign w_rs_start = 1'b0;
`endif

   assign w_take_d1 = (r_state == ST_WAIT_D1) | w_rs_start;
   assign w_one     = (data_count(r_status) == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_status <= 8'h00;
         r_d1     <= 8'h00;
         r_midi   <= 24'h0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_ferr) begin
            r_state <= ST_IDLE;
         end else if (w_strobe) begin
            unique case (1'b1)
               w_is_rt: begin
               end
               w_is_sys: begin
                  r_state  <= ST_IDLE;
                  r_status <= 8'h00;
               end
               w_is_chan: begin
                  r_status <= w_byte;
                  r_state  <= ST_WAIT_D1;
               end
               default: begin
                  if (r_state == ST_WAIT_D2) begin
                     r_midi  <= normalise(r_status, r_d1, w_byte);
                     r_valid <= 1'b1;
                     r_state <= ST_IDLE;
                  end else if (w_take_d1) begin
                     if (w_one) begin
                        r_midi  <= {r_status, w_byte, 8'h00};
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                     end else begin
                        r_d1    <= w_byte;
                        r_state <= ST_WAIT_D2;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign midi       = r_midi;
   assign midi_valid = r_valid;
   assign frame_err  = w_ferr;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Self-checking bench for midi_msg_assembler.
// Table vectors, corner sequences, and a random stream vs a message model.
module tb_midi_msg_assembler;

   localparam int CLK_HZ = 500_000;
   localparam int BAUD   = 31250;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int NV     = 12;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic [23:0] midi;
   logic        midi_valid;
   logic        frame_err;

   midi_msg_assembler #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .midi       (midi),
      .midi_valid (midi_valid),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [39:0] bytes;
      int          exp_n;
      logic [23:0] exp_midi;
   } vec_t;

   vec_t vt [NV];

   int errors = 0;
   int checks = 0;

   logic [23:0] cap_q [$];
   int          ferr_cnt = 0;
   int          viol = 0;
   logic [23:0] prev_midi;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_midi = midi;
      end else begin
         if (midi_valid) cap_q.push_back(midi);
         if (frame_err) ferr_cnt++;
         if (midi !== prev_midi && !midi_valid) viol++;
         prev_midi = midi;
      end
   end

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * CPB) @(posedge clk);
   endtask

   task automatic send_frame(
      input logic [7:0] b,
      input logic       good_stop
   );
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int j = 0; j < 8; j++) begin
         rx = b[j];
         repeat (CPB) @(posedge clk);
      end
      rx = good_stop;
      repeat (CPB) @(posedge clk);
      if (!good_stop) idle(1);
      rx = 1'b1;
   endtask

   // Reference model: message-level view with a queue of data bytes.
   logic [7:0]  m_status = 8'h00;
   bit          m_active = 1'b0;
   logic [7:0]  m_data [$];
   logic [23:0] exp_q [$];
   int          exp_ferr = 0;

   function automatic int need(input logic [7:0] s);
      return (s >= 8'hC0 && s <= 8'hDF) ? 1 : 2;
   endfunction

   task automatic model_byte(
      input logic [7:0] b,
      input bit         good
   );
      logic [7:0] st;
      logic [7:0] d2;
      if (!good) begin
         exp_ferr++;
         m_active = 1'b0;
         m_data.delete();
      end else if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
         m_status = 8'h00;
         m_active = 1'b0;
         m_data.delete();
      end else if (b >= 8'h80) begin
         m_status = b;
         m_active = 1'b1;
         m_data.delete();
      end else begin
`ifdef MIDI_RUNNING_STATUS_EN
         if (!m_active && m_status != 8'h00) m_active = 1'b1;
`endif
         if (m_active) begin
            m_data.push_back(b);
            if (m_data.size() == need(m_status)) begin
               st = m_status;
               d2 = (need(m_status) == 2) ? m_data[1] : 8'h00;
               if (st >= 8'h90 && st <= 8'h9F && d2 == 8'h00)
                  st = st - 8'h10;
               exp_q.push_back({st, m_data[0], d2});
               m_active = 1'b0;
               m_data.delete();
            end
         end
      end
   endtask

   logic [9:0]  fr;
   int          r;
   int          base_f;
   int          nchk;
   logic [7:0]  rb;
   bit          good;

   initial begin
      vt[0]  = '{3, {8'h90, 8'h45, 8'h64, 16'h0}, 1, 24'h904564};
`ifdef MIDI_RUNNING_STATUS_EN
      vt[1]  = '{2, {8'h48, 8'h50, 24'h0}, 1, 24'h904850};
`else
      vt[1]  = '{2, {8'h48, 8'h50, 24'h0}, 0, 24'h904564};
`endif
      vt[2]  = '{3, {8'h90, 8'h3C, 8'h00, 16'h0}, 1, 24'h803C00};
      vt[3]  = '{5, {8'h90, 8'hF8, 8'h45, 8'hFE, 8'h64}, 1,
                 24'h904564};
      vt[4]  = '{2, {8'hC5, 8'h22, 24'h0}, 1, 24'hC52200};
      vt[5]  = '{3, {8'hE1, 8'h10, 8'h40, 16'h0}, 1, 24'hE11040};
      vt[6]  = '{4, {8'h90, 8'h45, 8'hF2, 8'h64, 8'h0}, 0,
                 24'hE11040};
      vt[7]  = '{5, {8'h90, 8'h45, 8'h80, 8'h30, 8'h40}, 1,
                 24'h803040};
      vt[8]  = '{3, {8'h95, 8'h12, 8'h00, 16'h0}, 1, 24'h851200};
`ifdef MIDI_RUNNING_STATUS_EN
      vt[9]  = '{3, {8'hD3, 8'h7F, 8'h01, 16'h0}, 2, 24'hD30100};
      vt[10] = '{2, {8'hB0, 8'h07, 24'h0}, 0, 24'hD30100};
`else
      vt[9]  = '{3, {8'hD3, 8'h7F, 8'h01, 16'h0}, 1, 24'hD37F00};
      vt[10] = '{2, {8'hB0, 8'h07, 24'h0}, 0, 24'hD37F00};
`endif
      vt[11] = '{1, {8'h64, 32'h0}, 1, 24'hB00764};

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset midi", midi, 24'h0);
      chk("reset valid", midi_valid, 1'b0);
      chk("reset frame_err", frame_err, 1'b0);
      rst_n = 1'b1;
      idle(2);
      chk("post-reset midi", midi, 24'h0);

      for (int i = 0; i < NV; i++) begin
         cap_q.delete();
         for (int k = 0; k < vt[i].n; k++)
            send_frame(vt[i].bytes[39 - 8 * k -: 8], 1'b1);
         idle(2);
         chk($sformatf("vec%0d pulses", i), cap_q.size(),
             vt[i].exp_n);
         chk($sformatf("vec%0d midi", i), midi, vt[i].exp_midi);
      end

      // Short low glitch must not start a frame.
      cap_q.delete();
      base_f = ferr_cnt;
      @(posedge clk);
      rx = 1'b0;
      repeat (3) @(posedge clk);
      rx = 1'b1;
      idle(2);
      send_frame(8'h90, 1'b1);
      send_frame(8'h41, 1'b1);
      send_frame(8'h42, 1'b1);
      idle(2);
      chk("glitch pulses", cap_q.size(), 1);
      chk("glitch midi", midi, 24'h904142);
      chk("glitch ferr", ferr_cnt - base_f, 0);

      // Low stop bit.
      cap_q.delete();
      base_f = ferr_cnt;
      send_frame(8'h45, 1'b0);
      idle(1);
      chk("ferr count", ferr_cnt - base_f, 1);
      chk("ferr pulses", cap_q.size(), 0);
      send_frame(8'h90, 1'b1);
      send_frame(8'h40, 1'b1);
      send_frame(8'h7F, 1'b1);
      idle(2);
      chk("after ferr pulses", cap_q.size(), 1);
      chk("after ferr midi", midi, 24'h90407F);

      // Reset in the middle of the data2 frame.
      cap_q.delete();
      send_frame(8'h90, 1'b1);
      send_frame(8'h45, 1'b1);
      fr = {1'b1, 8'h64, 1'b0};
      for (int j = 0; j < 10; j++) begin
         rx = fr[j];
         if (j == 5) begin
            repeat (CPB / 2) @(posedge clk);
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("mid reset midi", midi, 24'h0);
            chk("mid reset valid", midi_valid, 1'b0);
            rst_n = 1'b1;
            repeat (CPB / 2 - 3) @(posedge clk);
         end else begin
            repeat (CPB) @(posedge clk);
         end
      end
      idle(12);
      chk("reset abort pulses", cap_q.size(), 0);
      chk("reset abort midi", midi, 24'h0);
      send_frame(8'h93, 1'b1);
      send_frame(8'h30, 1'b1);
      send_frame(8'h31, 1'b1);
      idle(2);
      chk("after reset pulses", cap_q.size(), 1);
      chk("after reset midi", midi, 24'h933031);

      // Random stream; start from a cleared stored status.
      send_frame(8'hF1, 1'b1);
      idle(1);
      cap_q.delete();
      exp_q.delete();
      base_f = ferr_cnt;
      for (int i = 0; i < 150; i++) begin
         r    = $urandom_range(0, 99);
         good = 1'b1;
         if (r < 30)
            rb = 8'h80 + 8'($urandom_range(0, 111));
         else if (r < 80)
            rb = 8'($urandom_range(0, 127));
         else if (r < 88)
            rb = 8'($urandom_range(248, 255));
         else if (r < 93)
            rb = 8'($urandom_range(240, 247));
         else begin
            rb   = 8'($urandom);
            good = 1'b0;
         end
         send_frame(rb, good);
         model_byte(rb, good);
      end
      idle(2);
      chk("rand count", cap_q.size(), exp_q.size());
      chk("rand ferr", ferr_cnt - base_f, exp_ferr);
      nchk = (cap_q.size() < exp_q.size()) ? cap_q.size()
                                            : exp_q.size();
      for (int i = 0; i < nchk; i++)
         chk($sformatf("rand msg%0d", i), cap_q[i], exp_q[i]);

      chk("midi only changes with valid", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
